reg_hold_pipe: RTL and testbench

- Parametrised successor of the single 24-bit hold register.
- D-stage signed delay line for the NPU datapath, with per-entry valid tags, global hold (stall), flush, and occupancy count.
- Sits between MAC/accumulator stages to align operand and partial-sum timing; hold freezes the entire line when downstream stalls.

---
 rtl/npu_pipe_pkg.sv | 12 +
 rtl/reg_hold_stage.sv | 53 +++++
 rtl/reg_hold_pipe.sv | 66 ++++++
 tb/tb_reg_hold_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/npu_pipe_pkg.sv
// Shared NPU pipeline defaults and the helper that sizes occupancy counters.
package npu_pipe_pkg;

  localparam int unsigned NPU_DW     = 24;
  localparam int unsigned NPU_PIPE_D = 4;

  // Enough bits to count from 0 up to and including d.
  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/reg_hold_stage.sv
// One delay-line stage: N-bit data register plus valid tag, with hold and flush.
// REG_HOLD_PIPE_ZERO_INVALID_EN: data loads 0 whenever the stage loads an invalid tag.
module reg_hold_stage
  import npu_pipe_pkg::*;
#(
  parameter int unsigned N = NPU_DW
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         hold_i,
  input  logic         flush_i,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic [N-1:0] data_o,
  output logic         valid_o
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!hold_i) begin
      data_d  = data_i;
      valid_d = valid_i;
`ifdef REG_HOLD_PIPE_ZERO_INVALID_EN
      if (!valid_i) data_d = '0;
`endif
    end
    // Flush clears the tag even while held; data stays frozen unless zeroing is enabled.
    if (flush_i) begin
      valid_d = 1'b0;
`ifdef REG_HOLD_PIPE_ZERO_INVALID_EN
      data_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/reg_hold_pipe.sv
// D-stage signed delay line with valid tags, global hold, flush and occupancy count.
// REG_HOLD_PIPE_ZERO_INVALID_EN: invalid stages carry zero data instead of stale values.
module reg_hold_pipe
  import npu_pipe_pkg::*;
#(
  parameter int unsigned N  = NPU_DW,
  parameter int unsigned D  = NPU_PIPE_D,
  localparam int unsigned CW = cnt_width(D)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  in_i,
  input  logic          in_valid_i,
  input  logic          hold_i,
  input  logic          flush_i,
  output logic [N-1:0]  out_o,
  output logic          out_valid_o,
  output logic [CW-1:0] count_o
);

  logic [N-1:0]  data_chain  [D+1];
  logic          valid_chain [D+1];
  logic [CW-1:0] count_q, count_d;

  assign data_chain[0]  = in_i;
  assign valid_chain[0] = in_valid_i;

  for (genvar k = 0; k < D; k++) begin : g_stage
    reg_hold_stage #(
      .N (N)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .hold_i  (hold_i),
      .flush_i (flush_i),
      .data_i  (data_chain[k]),
      .valid_i (valid_chain[k]),
      .data_o  (data_chain[k+1]),
      .valid_o (valid_chain[k+1])
    );
  end

  assign out_o       = data_chain[D];
  assign out_valid_o = valid_chain[D];

  // Tracks the popcount of tags without an adder tree: one in, one out per shift.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = count_q + CW'(in_valid_i) - CW'(out_valid_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_reg_hold_pipe.sv
// Directed bench for reg_hold_pipe: a D=4/N=24 instance and a D=1/N=8 instance.
module tb_reg_hold_pipe;

`ifdef REG_HOLD_PIPE_ZERO_INVALID_EN
  localparam bit ZeroInv = 1'b1;
`else
  localparam bit ZeroInv = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic [23:0] in;
  logic        in_valid, hold, flush;
  logic [23:0] out;
  logic        out_valid;
  logic [2:0]  count;

  logic [7:0]  in1;
  logic        in_valid1, hold1, flush1;
  logic [7:0]  out1;
  logic        out_valid1;
  logic [0:0]  count1;

  int tests_run = 0;
  int tests_failed = 0;

  reg_hold_pipe #(
    .N (24),
    .D (4)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_i        (in),
    .in_valid_i  (in_valid),
    .hold_i      (hold),
    .flush_i     (flush),
    .out_o       (out),
    .out_valid_o (out_valid),
    .count_o     (count)
  );

  reg_hold_pipe #(
    .N (8),
    .D (1)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_i        (in1),
    .in_valid_i  (in_valid1),
    .hold_i      (hold1),
    .flush_i     (flush1),
    .out_o       (out1),
    .out_valid_o (out_valid1),
    .count_o     (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [23:0] e_out, input logic e_ov,
                            input logic [2:0] e_cnt);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".ov"}, 32'(out_valid), 32'(e_ov));
    check({tag, ".cnt"}, 32'(count), 32'(e_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    in = '0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    in1 = '0; in_valid1 = 1'b0; hold1 = 1'b0; flush1 = 1'b0;
    tick();
    tick();
    check_main("reset", 24'h0, 1'b0, 3'd0);
    check("reset1.ov", 32'(out_valid1), 32'd0);
    rst_n = 1'b1;

    // D=1, N=8
    in1 = 8'h80; in_valid1 = 1'b1;
    tick();
    check("d1.out", 32'(out1), 32'h80);
    check("d1.ov", 32'(out_valid1), 32'd1);
    check("d1.cnt", 32'(count1), 32'd1);
    hold1 = 1'b1; in1 = 8'h11;
    tick();
    check("d1hold.out", 32'(out1), 32'h80);
    check("d1hold.ov", 32'(out_valid1), 32'd1);
    hold1 = 1'b0; flush1 = 1'b1; in1 = 8'h22;
    tick();
    check("d1flush.ov", 32'(out_valid1), 32'd0);
    check("d1flush.cnt", 32'(count1), 32'd0);
    check("d1flush.out", 32'(out1), ZeroInv ? 32'h0 : 32'h22);
    flush1 = 1'b0; in_valid1 = 1'b0; in1 = 8'h33;
    tick();
    check("d1bubble.out", 32'(out1), ZeroInv ? 32'h0 : 32'h33);
    check("d1bubble.ov", 32'(out_valid1), 32'd0);

    // Latency: -5 in, bubbles behind it
    in = 24'hFFFFFB; in_valid = 1'b1;
    tick();
    in = '0; in_valid = 1'b0;
    check_main("lat0", 24'h0, 1'b0, 3'd1);
    tick();
    check_main("lat1", 24'h0, 1'b0, 3'd1);
    tick();
    check_main("lat2", 24'h0, 1'b0, 3'd1);
    tick();
    check_main("lat3", 24'hFFFFFB, 1'b1, 3'd1);
    tick();
    check_main("lat4", 24'h0, 1'b0, 3'd0);

    // Hold: 10,20,30,40 then 3 held cycles offering 99
    for (int i = 1; i <= 4; i++) begin
      in = 24'(10 * i); in_valid = 1'b1;
      tick();
    end
    check_main("fill", 24'd10, 1'b1, 3'd4);
    hold = 1'b1; in = 24'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_main("hold", 24'd10, 1'b1, 3'd4);
    end
    hold = 1'b0; in = '0; in_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_main("drain", 24'(10 * i), 1'b1, 3'(5 - i));
    end
    tick();
    check("drain.ov", 32'(out_valid), 32'd0);
    check("drain.cnt", 32'(count), 32'd0);

    // Flush + hold on a full pipe
    for (int i = 1; i <= 4; i++) begin
      in = 24'(i); in_valid = 1'b1;
      tick();
    end
    check_main("full", 24'd1, 1'b1, 3'd4);
    flush = 1'b1; hold = 1'b1; in = 24'd77;
    tick();
    check_main("flushhold", ZeroInv ? 24'd0 : 24'd1, 1'b0, 3'd0);

    // Flush with an incoming valid sample: that sample must never surface
    hold = 1'b0; in = 24'd5;
    tick();
    check("flushin.cnt", 32'(count), 32'd0);
    flush = 1'b0; in_valid = 1'b0; in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flushin.ov", 32'(out_valid), 32'd0);
    end
    check("flushin.cnt2", 32'(count), 32'd0);

    // Steady state: continuous 1..20
    for (int i = 1; i <= 20; i++) begin
      in = 24'(i); in_valid = 1'b1;
      tick();
      check("stream.cnt", 32'(count), (i < 4) ? 32'(i) : 32'd4);
      check("stream.ov", 32'(out_valid), (i >= 4) ? 32'd1 : 32'd0);
      if (i >= 4) check("stream.out", 32'(out), 32'(i - 3));
    end
    in = '0; in_valid = 1'b0;
    tick();
    check_main("tail", 24'd18, 1'b1, 3'd3);

    // Asynchronous reset between edges with 3 stages valid
    #2;
    rst_n = 1'b0;
    #1;
    check_main("asyncrst", 24'h0, 1'b0, 3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_main("postrst", 24'h0, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
